demux_pry: RTL and testbench
============================

DEMUX_PRY -- requirements
Module: demux_pry

Interface
REQ-001 Parameter DAT_T, default logic [8-1:0], data element type.
REQ-002 Parameter WIDTH, default 9, number of destination outputs (WIDTH >= 2).
REQ-003 Parameter SPLIT, default 3, fan-in of the priority-encoder tree; SHALL NOT alter function.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_vld  input  1  source transfer valid.
REQ-007 s_pry  input  WIDTH  destination priority select, bit i requests output i.
REQ-008 s_dat  input  DAT_T  source data.
REQ-009 s_rdy  output  1  source transfer ready.
REQ-010 m_vld  output  WIDTH  per-destination valid, one-hot or zero.
REQ-011 m_dat  output  DAT_T  registered data, broadcast to all destinations.
REQ-012 m_rdy  input  WIDTH  per-destination ready.
REQ-013 drp_cnt  output  16  dropped-transfer count (present only per REQ-030).

Function
REQ-014 Destination SHALL be the highest index i with s_pry[i]=1, same priority order as mux_pry.
REQ-015 Block SHALL hold one output register with states EMPTY and FULL, plus registered destination index dst_q.
REQ-016 Input handshake: transfer when s_vld && s_rdy at rising clk edge.
REQ-017 s_rdy SHALL be 1 when EMPTY, or when FULL and m_rdy[dst_q]=1 (combinational path m_rdy -> s_rdy permitted).
REQ-018 Transfer with s_pry != 0: capture s_dat and destination, state FULL; m_vld[dst] asserts the next cycle (latency 1).
REQ-019 m_vld SHALL equal one-hot(dst_q) when FULL, all zero when EMPTY.
REQ-020 Output handshake: m_vld[dst_q] && m_rdy[dst_q]; m_rdy of non-selected outputs SHALL be ignored.
REQ-021 While FULL and unacknowledged, m_vld and m_dat SHALL remain stable.
REQ-022 FULL, output handshake, no new input transfer: state EMPTY next cycle.
REQ-023 FULL, output handshake and input transfer in same cycle: reload, stay FULL (full throughput, one transfer/cycle).
REQ-024 Transfer with s_pry == 0: data discarded, register not loaded; state follows REQ-022 rules as if no input; drp_cnt increments by 1.
REQ-025 drp_cnt SHALL saturate at 16'hFFFF.
REQ-026 m_dat when EMPTY SHALL retain last loaded value.

Reset
REQ-027 rst_n low SHALL immediately force state EMPTY, m_vld=0, m_dat=0, dst_q=0, drp_cnt=0, irrespective of clk.
REQ-028 Reset asserted while FULL SHALL discard the held item without output handshake.
REQ-029 s_rdy SHALL be 1 during and after reset (EMPTY).

Configuration
REQ-030 Macro DEMUX_PRY_DROP_CNT_EN defined: drp_cnt port and counter present per REQ-024/025; undefined: port and counter absent, zero-select transfers still accepted and silently discarded.

Verification
REQ-031 Reset, s_vld=0 -> m_vld=0, m_dat=0, s_rdy=1, drp_cnt=0.
REQ-032 s_pry=9'b0_0001_0100, s_dat=8'h5A, m_rdy all 1 -> next cycle m_vld=9'b0_0001_0000, m_dat=8'h5A; following cycle m_vld=0.
REQ-033 Item to output 2, m_rdy[2]=0 for 3 cycles, m_rdy[others]=1, s_vld held -> s_rdy=0, m_vld/m_dat stable 3 cycles; release -> s_rdy=1, back-to-back transfer, no bubble.
REQ-034 Stream of 9 one-hot s_pry (bit 0..8), s_dat=i, m_rdy all 1 -> m_vld[i] with m_dat=i each cycle, 1-cycle latency, no gaps.
REQ-035 s_pry=0 with s_vld=1 for 3 cycles -> s_rdy=1, m_vld=0, drp_cnt=3 (macro defined); no drp_cnt port (macro undefined).
REQ-036 FULL at output 5, rst_n pulsed low mid-cycle -> m_vld=0 immediately, item lost, first post-reset transfer routed correctly.

Source files
------------

// File: rtl/demux_pry.sv
// Priority demultiplexer: routes each source transfer to the highest-index
// requested destination through a single registered output stage.
// Optional dropped-transfer counter enabled by macro DEMUX_PRY_DROP_CNT_EN.
module demux_pry #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 9,
  parameter int  SPLIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_vld,
  input  logic [WIDTH-1:0] s_pry,
  input  DAT_T             s_dat,
  output logic             s_rdy,
  output logic [WIDTH-1:0] m_vld,
  output DAT_T             m_dat,
  input  logic [WIDTH-1:0] m_rdy
`ifdef DEMUX_PRY_DROP_CNT_EN
  ,
  output logic [15:0]      drp_cnt
`endif
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int NG = (WIDTH + SPLIT - 1) / SPLIT;

  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    dst_q, dst_d;
  DAT_T             dat_q, dat_d;
  logic [WIDTH-1:0] vld_q, vld_d;
`ifdef DEMUX_PRY_DROP_CNT_EN
  logic [15:0]      drp_q, drp_d;
`endif

  // Two-level encoder: last set bit inside each SPLIT-wide group, then the
  // highest group with any request. Padding keeps every index in range.
  logic [NG*SPLIT-1:0] pry_pad;
  logic [NG-1:0]       grp_any;
  logic [IW-1:0]       grp_idx [NG];
  logic [IW-1:0]       enc;
  logic                pry_any;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    pry_pad = (NG*SPLIT)'(s_pry);
    enc     = '0;
    for (int g = 0; g < NG; g++) begin
      grp_any[g] = 1'b0;
      grp_idx[g] = '0;
      for (int k = 0; k < SPLIT; k++) begin
        if (pry_pad[g*SPLIT + k]) begin
          grp_any[g] = 1'b1;
          grp_idx[g] = IW'(g*SPLIT + k);
        end
      end
    end
    for (int g = 0; g < NG; g++) begin
      if (grp_any[g]) enc = grp_idx[g];
    end
    pry_any = |grp_any;
  end

  logic out_hs, in_hs;

  assign s_rdy  = (state_q == EMPTY) || m_rdy[dst_q];
  assign out_hs = (state_q == FULL) && m_rdy[dst_q];
  assign in_hs  = s_vld && s_rdy;

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    dat_d   = dat_q;
    vld_d   = vld_q;
`ifdef DEMUX_PRY_DROP_CNT_EN
    drp_d   = drp_q;
    if (in_hs && !pry_any && (drp_q != 16'hFFFF)) drp_d = drp_q + 16'd1;
`endif
    if (in_hs && pry_any) begin
      state_d = FULL;
      dst_d   = enc;
      dat_d   = s_dat;
      vld_d   = {{(WIDTH-1){1'b0}}, 1'b1} << enc;
    end else if (out_hs) begin
      state_d = EMPTY;
      vld_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      dst_q   <= '0;
      dat_q   <= '0;
      vld_q   <= '0;
`ifdef DEMUX_PRY_DROP_CNT_EN
      drp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
`ifdef DEMUX_PRY_DROP_CNT_EN
      drp_q   <= drp_d;
`endif
    end
  end

  assign m_vld = vld_q;
  assign m_dat = dat_q;
`ifdef DEMUX_PRY_DROP_CNT_EN
  assign drp_cnt = drp_q;
`endif

endmodule

// File: tb/tb_demux_pry.sv
// Directed and random bench for demux_pry; a one-entry scoreboard predicts
// the held item, s_rdy, m_dat and (with DEMUX_PRY_DROP_CNT_EN) drp_cnt.
module tb_demux_pry;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_vld;
  logic [W-1:0] s_pry;
  logic [7:0]   s_dat;
  logic         s_rdy;
  logic [W-1:0] m_vld;
  logic [7:0]   m_dat;
  logic [W-1:0] m_rdy;
`ifdef DEMUX_PRY_DROP_CNT_EN
  logic [15:0]  drp_cnt;
`endif

  demux_pry dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_vld (s_vld),
    .s_pry (s_pry),
    .s_dat (s_dat),
    .s_rdy (s_rdy),
    .m_vld (m_vld),
    .m_dat (m_dat),
    .m_rdy (m_rdy)
`ifdef DEMUX_PRY_DROP_CNT_EN
    ,
    .drp_cnt (drp_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         dst;
    logic [7:0] dat;
  } item_t;

  item_t sb[$];
  logic [7:0] last_dat;
  int drops;
  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hi_idx(input logic [W-1:0] p);
    int r = -1;
    for (int i = 0; i < W; i++) if (p[i]) r = i;
    return r;
  endfunction

  // Check outputs at the falling edge, then advance the model across the
  // following rising edge using the inputs currently driven.
  task automatic cycle(input string tag);
    logic [W-1:0] exp_vld;
    logic         exp_rdy;
    item_t        it;
    @(negedge clk);
    exp_vld = '0;
    exp_rdy = 1'b1;
    if (sb.size() != 0) begin
      exp_vld[sb[0].dst] = 1'b1;
      exp_rdy = m_rdy[sb[0].dst];
    end
    check({tag, ".m_vld"}, 32'(m_vld), 32'(exp_vld));
    check({tag, ".m_dat"}, 32'(m_dat), 32'(last_dat));
    check({tag, ".s_rdy"}, 32'(s_rdy), 32'(exp_rdy));
`ifdef DEMUX_PRY_DROP_CNT_EN
    check({tag, ".drp_cnt"}, 32'(drp_cnt), 32'(drops));
`endif
    if (sb.size() != 0 && m_rdy[sb[0].dst]) void'(sb.pop_front());
    if (s_vld && exp_rdy) begin
      if (s_pry != '0) begin
        it.dst   = hi_idx(s_pry);
        it.dat   = s_dat;
        last_dat = s_dat;
        sb.push_back(it);
      end else begin
        drops++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; drops = 0; last_dat = 8'h00;
    rst_n = 1'b0; s_vld = 1'b0; s_pry = '0; s_dat = 8'h00; m_rdy = '0;

    // Reset state, sampled while reset is held
    #12;
    check("rst.m_vld", 32'(m_vld), 32'h0);
    check("rst.m_dat", 32'(m_dat), 32'h0);
    check("rst.s_rdy", 32'(s_rdy), 32'h1);
`ifdef DEMUX_PRY_DROP_CNT_EN
    check("rst.drp_cnt", 32'(drp_cnt), 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("idle");

    // Two requests: bit 4 wins over bit 2
    s_vld = 1'b1; s_pry = 9'b0_0001_0100; s_dat = 8'h5A; m_rdy = '1;
    cycle("pry.in");
    s_vld = 1'b0;
    cycle("pry.out");
    cycle("pry.drain");

    // Stall on output 2 for three cycles, other readies high
    s_vld = 1'b1; s_pry = 9'b0_0000_0100; s_dat = 8'h11; m_rdy = ~9'b0_0000_0100;
    cycle("stall.load");
    s_dat = 8'h22;
    for (int i = 0; i < 3; i++) cycle("stall.hold");
    m_rdy = '1;
    cycle("stall.release");
    s_vld = 1'b0;
    cycle("stall.next");
    cycle("stall.drain");

    // Back-to-back stream, one destination per cycle
    for (int i = 0; i < W; i++) begin
      s_vld = 1'b1; s_pry = W'(1) << i; s_dat = 8'(i); m_rdy = '1;
      cycle("stream");
    end
    s_vld = 1'b0;
    cycle("stream.tail");
    cycle("stream.drain");

    // Zero-select transfers are accepted and discarded
    s_vld = 1'b1; s_pry = '0; s_dat = 8'hFF;
    for (int i = 0; i < 3; i++) cycle("drop");
    s_vld = 1'b0;
    cycle("drop.after");
`ifdef DEMUX_PRY_DROP_CNT_EN
    check("drop.total", 32'(drp_cnt), 32'd3);
`endif

    // Random traffic, including unselected ready toggling
    for (int i = 0; i < 40; i++) begin
      s_vld = ($urandom_range(3) != 0);
      s_pry = ($urandom_range(4) == 0) ? '0 : W'($urandom);
      s_dat = 8'($urandom);
      m_rdy = W'($urandom);
      cycle("rand");
    end
    s_vld = 1'b0; m_rdy = '1;
    cycle("rand.drain");
    cycle("rand.idle");

    // Held item at output 5 lost to an asynchronous mid-cycle reset
    s_vld = 1'b1; s_pry = 9'b0_0010_0000; s_dat = 8'h77; m_rdy = ~9'b0_0010_0000;
    cycle("arst.load");
    s_vld = 1'b0;
    cycle("arst.held");
    #2 rst_n = 1'b0;
    #1;
    sb.delete(); last_dat = 8'h00; drops = 0;
    check("arst.m_vld", 32'(m_vld), 32'h0);
    check("arst.m_dat", 32'(m_dat), 32'h0);
    check("arst.s_rdy", 32'(s_rdy), 32'h1);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    s_vld = 1'b1; s_pry = 9'b0_0000_1010; s_dat = 8'hC3; m_rdy = '1;
    cycle("arst.in");
    s_vld = 1'b0;
    cycle("arst.out");
    cycle("arst.drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
